poly_note_player: RTL

//  Parametrised, polyphonic successor to the single-channel note player: NUM_CH independent

---
 rtl/poly_note_pkg.sv | 23 ++
 rtl/note_channel.sv | 80 ++++++++
 rtl/poly_note_player.sv | 55 +++++
 3 files changed

// File: rtl/poly_note_pkg.sv
// rtl/poly_note_pkg.sv - shared state encoding and helpers for the polyphonic note player
package poly_note_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } ch_state_e;

  // Widest tone vector the popcount helper accepts.
  localparam int MAX_CH = 32;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
    int unsigned n = 0;
    for (int i = 0; i < MAX_CH; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/note_channel.sv
// rtl/note_channel.sv - one square-wave tone channel with full-length release
module note_channel
  import poly_note_pkg::*;
#(
  parameter int FREQ_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ring,
  input  logic [FREQ_W-1:0] freq,
  output logic              tone,
  output logic              active
);

  ch_state_e         state;
  logic [FREQ_W-1:0] div;
  logic [FREQ_W-1:0] cnt;
  logic              half_end;

  assign half_end = (cnt == div - FREQ_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      tone   <= 1'b0;
      active <= 1'b0;
      cnt    <= '0;
      div    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ring && freq != '0) begin
            state  <= ST_RUN;
            active <= 1'b1;
            div    <= freq;
            cnt    <= '0;
            tone   <= 1'b1;
          end else begin
            tone <= 1'b0;
          end
        end
        ST_RUN, ST_RELEASE: begin
          if (ring) begin
            // Re-ring from RELEASE keeps cnt and phase running (legato).
            state <= ST_RUN;
            if (half_end) begin
              cnt <= '0;
              if (freq == '0) begin
                state  <= ST_IDLE;
                active <= 1'b0;
                tone   <= 1'b0;
              end else begin
                tone <= ~tone;
                div  <= freq;
              end
            end else begin
              cnt <= cnt + FREQ_W'(1);
            end
          end else if (!tone || half_end) begin
            state  <= ST_IDLE;
            active <= 1'b0;
            tone   <= 1'b0;
            cnt    <= '0;
          end else begin
            // Released mid-high: finish the pulse before going idle.
            state <= ST_RELEASE;
            cnt   <= cnt + FREQ_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          active <= 1'b0;
          tone   <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/poly_note_player.sv
// rtl/poly_note_player.sv - NUM_CH tone channels, live-voice count and sigma-delta speaker output
module poly_note_player
  import poly_note_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int FREQ_W = 13,
  parameter int CNT_W  = cnt_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ring,
  input  logic [NUM_CH*FREQ_W-1:0] freq,
  output logic [NUM_CH-1:0]        tone,
  output logic [NUM_CH-1:0]        active,
  output logic [CNT_W-1:0]         mix,
  output logic                     o
);

  localparam logic [CNT_W:0] FULL = (CNT_W + 1)'(NUM_CH);

  logic [CNT_W-1:0] acc;
  logic [CNT_W:0]   sum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    note_channel #(.FREQ_W(FREQ_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .ring   (ring[i]),
      .freq   (freq[i*FREQ_W +: FREQ_W]),
      .tone   (tone[i]),
      .active (active[i])
    );
  end

  // One extra bit so acc + mix never wraps before the threshold compare.
  assign sum = {1'b0, acc} + {1'b0, mix};

  always_ff @(posedge clk) begin
    if (rst) begin
      mix <= '0;
      acc <= '0;
      o   <= 1'b0;
    end else begin
      mix <= CNT_W'(popcount(MAX_CH'(tone)));
      if (sum >= FULL) begin
        o   <= 1'b1;
        acc <= CNT_W'(sum - FULL);
      end else begin
        o   <= 1'b0;
        acc <= CNT_W'(sum);
      end
    end
  end

endmodule
